// File: rtl/multicycle_cpu.sv
// Multicycle CPU: one shared ALU and register file sequenced by an FSM.
// Supports add/sub/and/or/slt, addi, lw/sw with a ready handshake, beq, j,
// and halts in a trap state on any illegal instruction.
module multicycle_cpu #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned PC_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [DATA_W-1:0]        dmem_addr,
  output logic [DATA_W-1:0]        dmem_wdata,
  output logic                     dmem_we,
  output logic                     dmem_re,
  input  logic [DATA_W-1:0]        dmem_rdata,
  input  logic                     dmem_ready,
  output logic [PC_W-1:0]          pc,
  output logic [2:0]               state,
  output logic                     instr_done,
  output logic                     trap,
  input  logic [$clog2(NREG)-1:0]  dbg_sel,
  output logic [DATA_W-1:0]        dbg_reg
);

  localparam int unsigned RA_W = $clog2(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   alu_q, alu_d, mdr_q, mdr_d;
  logic                trap_q, trap_d;
  logic [DATA_W-1:0]   regs [NREG];

  logic [5:0]          op, funct;
  logic [RA_W-1:0]     rs, rt, rd;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     br_off;
  logic                legal;
  logic [DATA_W-1:0]   alu_b, alu_y;
  logic                reg_we;
  logic [RA_W-1:0]     reg_waddr;
  logic [DATA_W-1:0]   reg_wdata;

  // Instruction fields; register indices alias onto the low RA_W bits
  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[21 +: RA_W];
  assign rt     = ir_q[16 +: RA_W];
  assign rd     = ir_q[11 +: RA_W];
  assign imm    = DATA_W'($signed(ir_q[15:0]));
  assign br_off = PC_W'($signed(ir_q[15:0]));

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign trap       = trap_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign dbg_reg    = regs[dbg_sel];

  // Legal-instruction decode
  always_comb begin
    legal = 1'b0;
    if (op == OP_R) begin
      legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    end else begin
      legal = op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    end
  end

  // Shared ALU: R-type ops, or A + imm for addi and address generation
  always_comb begin
    alu_b = imm;
    if (op == OP_R) alu_b = b_q;
    alu_y = a_q + alu_b;
    if (op == OP_R) begin
      case (funct)
        F_SUB:   alu_y = a_q - b_q;
        F_AND:   alu_y = a_q & b_q;
        F_OR:    alu_y = a_q | b_q;
        F_SLT:   alu_y = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
        default: alu_y = a_q + b_q;
      endcase
    end
  end

  // Next-state, datapath next values, strobes and retire flag
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    trap_d     = trap_q;
    reg_we     = 1'b0;
    reg_waddr  = rt;
    reg_wdata  = alu_q;
    instr_done = 1'b0;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = regs[rs];
        b_d = regs[rt];
        if (!legal) begin
          trap_d  = 1'b1;
          state_d = S_TRAP;
        end else if (op == OP_J) begin
          pc_d       = PC_W'(ir_q[25:0]);
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_y;
        if (op == OP_BEQ) begin
          if (a_q == b_q) pc_d = pc_q + br_off;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_re = (op == OP_LW);
        dmem_we = (op == OP_SW);
        if (dmem_ready) begin
          if (op == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (op == OP_R)  reg_waddr = rd;
        if (op == OP_LW) reg_wdata = mdr_q;
      end
      S_TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // State, datapath and register-file update; r0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      trap_q  <= 1'b0;
      regs    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
      if (reg_we && (reg_waddr != '0)) regs[reg_waddr] <= reg_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Testbench for multicycle_cpu: instruction-level reference model with
// per-cycle output checks, directed programs and random programs.
module tb_multicycle_cpu;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned RA = $clog2(NR);

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [PW-1:0]  imem_addr, pc;
  logic [31:0]    imem_rdata;
  logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata, dbg_reg;
  logic           dmem_we, dmem_re, dmem_ready, instr_done, trap;
  logic [2:0]     state;
  logic [RA-1:0]  dbg_sel;

  logic [31:0]    imem [256];
  assign imem_rdata = imem[imem_addr];

  multicycle_cpu #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .state(state), .instr_done(instr_done), .trap(trap),
    .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Reference model: architectural state plus position within current instruction
  logic [DW-1:0]  regs_m [NR];
  logic [DW-1:0]  dmem_m [256];
  int             kfix [256];
  logic [PW-1:0]  m_pc, m_npc;
  kind_t          m_kind;
  int             m_off, m_lat, m_k, m_dest;
  logic [DW-1:0]  m_addr, m_wdata, m_res;
  bit             started = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_ins(int t);
    return {6'h02, 26'(t)};
  endfunction

  // Work out what the instruction at m_pc does and how long it takes
  task automatic model_start();
    logic [31:0]   ins, sx;
    logic [DW-1:0] a, b, imm;
    int            rs, rt, rd;
    ins = imem[m_pc];
    sx  = {{16{ins[15]}}, ins[15:0]};
    rs  = int'(ins[21 +: RA]);
    rt  = int'(ins[16 +: RA]);
    rd  = int'(ins[11 +: RA]);
    a   = regs_m[rs];
    b   = regs_m[rt];
    imm = sx[DW-1:0];
    m_off = 0; m_dest = -1; m_k = 0;
    m_addr = '0; m_wdata = '0; m_res = '0;
    m_npc  = PW'(m_pc + PW'(1));
    m_kind = K_ILL;
    case (ins[31:26])
      6'h00: begin
        m_kind = K_R; m_dest = rd;
        case (ins[5:0])
          6'h20: m_res = a + b;
          6'h22: m_res = a - b;
          6'h24: m_res = a & b;
          6'h25: m_res = a | b;
          6'h2A: m_res = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
          default: m_kind = K_ILL;
        endcase
      end
      6'h08: begin m_kind = K_ADDI; m_dest = rt; m_res = a + imm; end
      6'h23: begin m_kind = K_LW; m_dest = rt; m_addr = a + imm; end
      6'h2B: begin m_kind = K_SW; m_addr = a + imm; m_wdata = b; end
      6'h04: begin
        m_kind = K_BEQ;
        if (a == b) m_npc = PW'(m_pc + PW'(1) + sx[PW-1:0]);
      end
      6'h02: begin m_kind = K_J; m_npc = ins[PW-1:0]; end
      default: m_kind = K_ILL;
    endcase
    if (m_kind == K_LW || m_kind == K_SW)
      m_k = (kfix[m_pc] >= 0) ? kfix[m_pc] : int'($urandom_range(0, 4));
    case (m_kind)
      K_J:          m_lat = 2;
      K_BEQ:        m_lat = 3;
      K_R, K_ADDI:  m_lat = 4;
      K_SW:         m_lat = 4 + m_k;
      K_LW:         m_lat = 5 + m_k;
      default:      m_lat = 1 << 30;
    endcase
  endtask

  task automatic model_retire();
    if ((m_kind == K_R || m_kind == K_ADDI) && m_dest > 0) regs_m[m_dest] = m_res;
    if (m_kind == K_LW && m_dest > 0) regs_m[m_dest] = dmem_m[m_addr];
    if (m_kind == K_SW) dmem_m[m_addr] = m_wdata;
    m_pc = m_npc;
    model_start();
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) regs_m[i] = '0;
    m_pc = '0;
    started = 1'b1;
    model_start();
  endtask

  function automatic logic [2:0] exp_state();
    if (m_off == 0) return 3'd0;
    if (m_off == 1) return 3'd1;
    if (m_kind == K_ILL) return 3'd7;
    if (m_off == 2) return 3'd2;
    if ((m_kind == K_LW || m_kind == K_SW) && m_off <= 3 + m_k) return 3'd3;
    return 3'd4;
  endfunction

  // Memory responder and debug select follow the model's timeline
  task automatic drive_inputs();
    bit mem_now;
    dbg_sel = RA'($urandom_range(0, NR - 1));
    mem_now = (m_kind == K_LW || m_kind == K_SW) && m_off >= 3;
    if (mem_now) dmem_ready = (m_off == 3 + m_k);
    else         dmem_ready = 1'($urandom_range(0, 1));
    if (m_kind == K_LW && m_off == 3 + m_k) dmem_rdata = dmem_m[m_addr];
    else                                     dmem_rdata = DW'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else if (started) begin
      if (m_off == m_lat - 1) model_retire();
      else m_off++;
    end
    drive_inputs();
  endtask

  task automatic peek(input string name, input int r, input logic [DW-1:0] exp);
    step();
    dbg_sel = RA'(r);
    #1;
    check(name, 32'(dbg_reg), 32'(exp));
  endtask

  task automatic begin_phase();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      kfix[i] = -1;
    end
  endtask

  task automatic end_reset();
    step();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    int sel;
    logic [5:0] fn;
    logic [15:0] off;
    sel = int'($urandom_range(0, 99));
    case ($urandom_range(0, 4))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    off = 16'(int'($urandom_range(0, 16)) - 8);
    if (sel < 35) return r_ins(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), fn);
    if (sel < 55) return i_ins(6'h08, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
    if (sel < 67) return i_ins(6'h23, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
    if (sel < 79) return i_ins(6'h2B, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
    if (sel < 89) return i_ins(6'h04, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), off);
    if (sel < 95) return j_ins(int'($urandom_range(0, 255)));
    if (sel < 97) return {6'h3F, 26'($urandom)};
    return r_ins(1, 2, 3, 6'h21);
  endfunction

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : cmp
    logic [PW-1:0] epc;
    bit mem_act;
    if (started) begin
      epc = (m_off == 0) ? m_pc : PW'(m_pc + PW'(1));
      mem_act = (m_kind == K_LW || m_kind == K_SW) && m_off >= 3 && m_off <= 3 + m_k;
      check("pc", 32'(pc), 32'(epc));
      check("imem_addr", 32'(imem_addr), 32'(epc));
      check("state", 32'(state), 32'(exp_state()));
      check("instr_done", 32'(instr_done), 32'(m_kind != K_ILL && m_off == m_lat - 1));
      check("trap", 32'(trap), 32'(m_kind == K_ILL && m_off >= 2));
      check("dmem_re", 32'(dmem_re), 32'(mem_act && m_kind == K_LW));
      check("dmem_we", 32'(dmem_we), 32'(mem_act && m_kind == K_SW));
      if (mem_act) check("dmem_addr", 32'(dmem_addr), 32'(m_addr));
      if (mem_act && m_kind == K_SW) check("dmem_wdata", 32'(dmem_wdata), 32'(m_wdata));
      check("dbg_reg", 32'(dbg_reg), 32'(regs_m[dbg_sel]));
      if (instr_done) done_cnt++;
    end
  end

  initial begin
    rst = 1'b0; dbg_sel = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    m_kind = K_ILL; m_off = 0; m_lat = 1; m_k = 0; m_pc = '0;
    for (int i = 0; i < 256; i++) dmem_m[i] = DW'($urandom);

    // Arithmetic, memory, r0, aliasing, branch-not-taken, jump wrap, trap
    begin_phase();
    imem[0]  = i_ins(6'h08, 0, 1, 16'd5);
    imem[1]  = i_ins(6'h08, 0, 2, 16'd3);
    imem[2]  = r_ins(1, 2, 3, 6'h20);
    imem[3]  = r_ins(2, 1, 4, 6'h2A);
    imem[4]  = r_ins(2, 1, 5, 6'h22);
    imem[5]  = i_ins(6'h08, 0, 6, 16'hFFFF);
    imem[6]  = r_ins(6, 0, 7, 6'h2A);
    imem[7]  = i_ins(6'h2B, 0, 3, 16'd2);  kfix[7] = 3;
    imem[8]  = i_ins(6'h23, 0, 6, 16'd2);  kfix[8] = 0;
    imem[9]  = i_ins(6'h08, 0, 0, 16'd9);
    imem[10] = i_ins(6'h08, 0, 9, 16'd7);
    imem[11] = i_ins(6'h04, 1, 2, 16'd5);
    imem[12] = j_ins(8'hFF);
    imem[255] = 32'hFC00_0000;
    step();
    end_reset();
    done_cnt = 0;
    repeat (12) step();
    dbg_sel = RA'(3);
    #1;
    check("r3_after_12", 32'(dbg_reg), 32'h08);
    check("pc_after_12", 32'(pc), 32'h03);
    for (int c = 0; c < 300 && !(m_kind == K_ILL && m_off >= 3); c++) step();
    check("a_retired", 32'(done_cnt), 32'd13);
    check("a_pc_wrap", 32'(pc), 32'h00);
    check("a_trap", 32'(trap), 32'h1);
    check("a_state", 32'(state), 32'h7);
    peek("a_r0", 0, 8'h00);
    peek("a_r1_alias", 1, 8'h07);
    peek("a_r2", 2, 8'h03);
    peek("a_r3", 3, 8'h08);
    peek("a_r4_slt", 4, 8'h01);
    peek("a_r5_sub", 5, 8'hFE);
    peek("a_r6_lw", 6, 8'h08);
    peek("a_r7_slt_signed", 7, 8'h01);

    // Taken beq looping back onto itself
    begin_phase();
    imem[0] = i_ins(6'h08, 0, 1, 16'd5);
    imem[1] = i_ins(6'h08, 0, 2, 16'd3);
    imem[2] = r_ins(1, 2, 3, 6'h20);
    imem[3] = r_ins(1, 2, 4, 6'h25);
    imem[4] = i_ins(6'h04, 1, 1, 16'hFFFF);
    end_reset();
    repeat (31) step();
    #1;
    check("b_beq_loop_pc", 32'(pc), 32'h04);
    check("b_beq_loop_state", 32'(state), 32'h0);

    // Illegal opcode at pc=6, held in trap, then reset
    begin_phase();
    for (int i = 0; i < 6; i++) imem[i] = i_ins(6'h08, 0, i + 1, 16'((i + 1) * 10));
    imem[6] = 32'hFC00_0000;
    end_reset();
    repeat (46) step();
    #1;
    check("c_trap_pc", 32'(pc), 32'h07);
    check("c_trap", 32'(trap), 32'h1);
    check("c_trap_state", 32'(state), 32'h7);
    peek("c_r6_kept", 6, 8'd60);
    rst = 1'b0;
    step();
    rst = 1'b1;
    dbg_sel = RA'(1);
    #1;
    check("c_reset_pc", 32'(pc), 32'h00);
    check("c_reset_trap", 32'(trap), 32'h0);
    check("c_reset_r1", 32'(dbg_reg), 32'h00);

    // Reset while a load is stalled in MEM
    begin_phase();
    imem[0] = i_ins(6'h23, 0, 1, 16'd2);  kfix[0] = 10;
    imem[1] = i_ins(6'h08, 0, 2, 16'd1);
    end_reset();
    repeat (5) step();
    #1;
    check("d_stall_state", 32'(state), 32'h3);
    check("d_stall_re", 32'(dmem_re), 32'h1);
    check("d_stall_addr", 32'(dmem_addr), 32'h02);
    rst = 1'b0;
    step();
    rst = 1'b1;
    dbg_sel = RA'(1);
    #1;
    check("d_abort_re", 32'(dmem_re), 32'h0);
    check("d_abort_we", 32'(dmem_we), 32'h0);
    check("d_abort_state", 32'(state), 32'h0);
    check("d_abort_r1", 32'(dbg_reg), 32'h00);
    repeat (30) step();

    // Random programs with random memory stalls; traps recover via reset
    for (int p = 0; p < 4; p++) begin
      begin_phase();
      for (int i = 0; i < 256; i++) imem[i] = rand_ins();
      end_reset();
      for (int c = 0; c < 1500; c++) begin
        rst = !(m_kind == K_ILL && m_off >= 6);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
